decode_issue_unit: RTL and testbench
====================================

Name: decode_issue_unit

Overview:
- Parametrised, pipelined successor to the base-core decode unit.
- Decodes one RV32I instruction per cycle. Reads the integer register file with same-cycle writeback bypass. Derives the immediate format from the opcode, with no extend_sel input.
- Tracks in-flight destination registers in a busy scoreboard and stalls RAW hazards.
- Presents results in a registered output stage with valid/ready handshakes on both sides. Sits between fetch and execute.

Parameters:
- CORE, 0, core index used in scan messages.
- ADDRESS_BITS, 32, width of PC, branch_target, JAL_target and out_PC.
- DATA_WIDTH, 32, register and immediate width; must be ≥32.
- REG_COUNT, 32, architectural registers; index width is 5 bits.
- SCAN_CYCLES_MIN, 0, first cycle for which scan printing is enabled.
- SCAN_CYCLES_MAX, 1000, last cycle for which scan printing is enabled.

Ports:
- clock  in  1  Core clock; all state updates on the rising edge.
- reset  in  1  Synchronous, active-high reset.
- PC  in  ADDRESS_BITS  PC of the incoming instruction.
- instruction  in  32  Incoming instruction.
- in_valid  in  1  Fetch presents PC/instruction.
- in_ready  out  1  Decode accepts this cycle.
- write  in  1  Writeback enable.
- write_reg  in  5  Writeback register index.
- write_data  in  DATA_WIDTH  Writeback data.
- flush  in  1  Squash output stage and clear scoreboard.
- out_valid  out  1  Output stage holds a decoded instruction.
- out_ready  in  1  Execute consumes the output.
- out_PC  out  ADDRESS_BITS  Registered PC.
- rs1_data  out  DATA_WIDTH  Registered source operand 1.
- rs2_data  out  DATA_WIDTH  Registered source operand 2.
- rd  out  5  Registered destination register index.
- opcode  out  7  Registered opcode field.
- funct3  out  3  Registered funct3 field.
- funct7  out  7  Registered funct7 field.
- extend_imm  out  DATA_WIDTH  Sign-extended immediate.
- branch_target  out  ADDRESS_BITS  PC + B-immediate.
- JAL_target  out  ADDRESS_BITS  PC + J-immediate.
- scan  in  1  Enables per-cycle $display of decode state within the SCAN window.

Behaviour:
- Reset: out_valid=0. All data outputs are 0. Scoreboard cleared. Register file zeroed. in_ready=0 during reset.
- Accept condition: accept = in_valid && in_ready.
- Ready rule: in_ready = (!out_valid || out_ready) && !hazard && !flush.
- Latency: 1 cycle. Fields captured on accept appear with out_valid=1 the next cycle.
- Backpressure: while out_valid && !out_ready, all outputs hold stable.
- Output drain: out_valid clears on the out_ready edge if no new accept occurs. Back-to-back accepts sustain 1 instruction per cycle.
- Immediate format, chosen by opcode:
  - I: 0x13, 0x03, 0x67, 0x73.
  - S: 0x23.
  - B: 0x63.
  - U: 0x37, 0x17.
  - J: 0x6F.
  - Any other opcode: immediate is 0.
  - All immediates are sign-extended to DATA_WIDTH.
- Target arithmetic: branch_target = PC + B-imm and JAL_target = PC + J-imm. Both are computed for every instruction, mod 2^ADDRESS_BITS with wrap-around and no overflow flag.
- Register file: a write occurs when write && write_reg≠0. Writes to x0 are ignored, and x0 always reads 0.
- Bypass: if write && write_reg==rsN && rsN≠0 in the accept cycle, rsN_data captures write_data.
- rs1 usage: rs1 is used by every opcode except 0x37, 0x17 and 0x6F.
- rs2 usage: rs2 is used by 0x23, 0x63 and 0x33.
- Writes-rd condition: the instruction writes rd if its opcode is 0x13, 0x03, 0x33, 0x37, 0x17, 0x6F or 0x67, and rd≠0.
- Hazard: hazard = OR over used rsN of (busy[rsN] && !(write && write_reg==rsN)).
- Scoreboard set/clear: on accept of a writes-rd instruction, busy[rd] is set. A writeback clears busy[write_reg].
  - Same-cycle set and clear of the same index: set wins.
  - busy[0] is never set.
- Flush: next cycle out_valid=0 and all busy bits are 0.
  - The accept is blocked in the flush cycle.
  - A writeback in the flush cycle still updates the register file.
  - Upstream asserts flush only after older writers have retired.
- Reset mid-operation: overrides flush and all handshakes, and restores the full reset state on the next edge.

Test Plan:
- Reset 5 cycles, then in_valid=1, PC=0x4, instr=0xfe010113, out_ready=1. Required: next cycle out_valid=1, rd=2, opcode=0x13, funct3=0, extend_imm=0xffffffe0.
- Back-to-back 0x00112e23 then 0x00812c23. Required: consecutive cycles show opcode 0x23, funct3=2, with extend_imm 0x1c then 0x18; in_ready stays 1 throughout.
- Hazard: 0x00400793 (a5 busy), then 0xfef42623. Required:
  - in_ready=0 until write=1, write_reg=15, write_data=4.
  - Accept occurs in that same cycle, with rs2_data=4 via bypass and extend_imm=0xffffffec.
  - busy[15] is then clear.
- Targets: PC=0x100 with 0x00000463 gives branch_target=0x108. PC=0x20 with 0x010000ef gives JAL_target=0x30 and rd=1.
- Backpressure/flush:
  - With out_ready=0, outputs hold for 4 cycles and in_ready=0.
  - Then flush=1 gives out_valid=0 and all busy bits clear. A following read of a formerly busy register does not stall.
- Reset mid-stream: assert reset with out_valid=1 and busy[8] set. Required: next cycle out_valid=0, scoreboard clear, and x8 reads 0.

Source files
------------

// File: rtl/decode_issue_unit.sv
// RV32I decode/issue stage: register-file read with writeback bypass, opcode-driven
// immediate extraction, busy-bit RAW scoreboard and a registered valid/ready output stage.
module decode_issue_unit #(
    parameter int CORE            = 0,
    parameter int ADDRESS_BITS    = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int REG_COUNT       = 32,
    parameter int SCAN_CYCLES_MIN = 0,
    parameter int SCAN_CYCLES_MAX = 1000
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [ADDRESS_BITS-1:0] PC,
    input  logic [31:0]             instruction,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    write,
    input  logic [4:0]              write_reg,
    input  logic [DATA_WIDTH-1:0]   write_data,
    input  logic                    flush,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [ADDRESS_BITS-1:0] out_PC,
    output logic [DATA_WIDTH-1:0]   rs1_data,
    output logic [DATA_WIDTH-1:0]   rs2_data,
    output logic [4:0]              rd,
    output logic [6:0]              opcode,
    output logic [2:0]              funct3,
    output logic [6:0]              funct7,
    output logic [DATA_WIDTH-1:0]   extend_imm,
    output logic [ADDRESS_BITS-1:0] branch_target,
    output logic [ADDRESS_BITS-1:0] JAL_target,
    input  logic                    scan
);

    localparam logic [6:0] OP_IMM    = 7'h13;
    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_JALR   = 7'h67;
    localparam logic [6:0] OP_SYSTEM = 7'h73;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_LUI    = 7'h37;
    localparam logic [6:0] OP_AUIPC  = 7'h17;
    localparam logic [6:0] OP_JAL    = 7'h6F;
    localparam logic [6:0] OP_REG    = 7'h33;

    function automatic logic signed [31:0] b_imm(input logic [31:0] ins);
        return {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
    endfunction

    function automatic logic signed [31:0] j_imm(input logic [31:0] ins);
        return {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
    endfunction

    function automatic logic signed [31:0] decode_imm(input logic [31:0] ins);
        logic signed [31:0] v;
        case (ins[6:0])
            OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM: v = {{20{ins[31]}}, ins[31:20]};
            OP_STORE:                            v = {{20{ins[31]}}, ins[31:25], ins[11:7]};
            OP_BRANCH:                           v = b_imm(ins);
            OP_LUI, OP_AUIPC:                    v = {ins[31:12], 12'b0};
            OP_JAL:                              v = j_imm(ins);
            default:                             v = '0;
        endcase
        return v;
    endfunction

    // Size casts of a signed operand sign-extend (or truncate) to the target width.
    function automatic logic [DATA_WIDTH-1:0] sext_data(input logic signed [31:0] v);
        return DATA_WIDTH'(v);
    endfunction

    function automatic logic [ADDRESS_BITS-1:0] sext_addr(input logic signed [31:0] v);
        return ADDRESS_BITS'(v);
    endfunction

    function automatic logic uses_rs1(input logic [6:0] op);
        return !(op == OP_LUI || op == OP_AUIPC || op == OP_JAL);
    endfunction

    function automatic logic uses_rs2(input logic [6:0] op);
        return (op == OP_STORE || op == OP_BRANCH || op == OP_REG);
    endfunction

    function automatic logic writes_rd(input logic [6:0] op, input logic [4:0] idx);
        return (idx != 5'd0) &&
               (op == OP_IMM || op == OP_LOAD || op == OP_REG || op == OP_LUI ||
                op == OP_AUIPC || op == OP_JAL || op == OP_JALR);
    endfunction

    logic [DATA_WIDTH-1:0]   rf_q [REG_COUNT];
    logic [REG_COUNT-1:0]    busy_q, busy_d;

    logic                    out_valid_q, out_valid_d;
    logic [ADDRESS_BITS-1:0] pc_q, pc_d;
    logic [DATA_WIDTH-1:0]   rs1_q, rs1_d;
    logic [DATA_WIDTH-1:0]   rs2_q, rs2_d;
    logic [4:0]              rd_q, rd_d;
    logic [6:0]              opcode_q, opcode_d;
    logic [2:0]              funct3_q, funct3_d;
    logic [6:0]              funct7_q, funct7_d;
    logic [DATA_WIDTH-1:0]   imm_q, imm_d;
    logic [ADDRESS_BITS-1:0] btgt_q, btgt_d;
    logic [ADDRESS_BITS-1:0] jtgt_q, jtgt_d;

    logic [6:0] op_w;
    logic [4:0] rs1_w, rs2_w, rd_w;
    logic       byp1, byp2, hazard, accept;
    logic [DATA_WIDTH-1:0] rs1_rd, rs2_rd;

    assign op_w  = instruction[6:0];
    assign rd_w  = instruction[11:7];
    assign rs1_w = instruction[19:15];
    assign rs2_w = instruction[24:20];

    // A writeback landing in the same cycle both bypasses the read and resolves the hazard.
    assign byp1 = write && (write_reg == rs1_w) && (rs1_w != 5'd0);
    assign byp2 = write && (write_reg == rs2_w) && (rs2_w != 5'd0);

    assign rs1_rd = (rs1_w == 5'd0) ? '0 : (byp1 ? write_data : rf_q[rs1_w]);
    assign rs2_rd = (rs2_w == 5'd0) ? '0 : (byp2 ? write_data : rf_q[rs2_w]);

    assign hazard = (uses_rs1(op_w) && busy_q[rs1_w] && !(write && write_reg == rs1_w)) ||
                    (uses_rs2(op_w) && busy_q[rs2_w] && !(write && write_reg == rs2_w));

    assign in_ready = !reset && (!out_valid_q || out_ready) && !hazard && !flush;
    assign accept   = in_valid && in_ready;

    always_comb begin
        out_valid_d = out_valid_q;
        pc_d        = pc_q;
        rs1_d       = rs1_q;
        rs2_d       = rs2_q;
        rd_d        = rd_q;
        opcode_d    = opcode_q;
        funct3_d    = funct3_q;
        funct7_d    = funct7_q;
        imm_d       = imm_q;
        btgt_d      = btgt_q;
        jtgt_d      = jtgt_q;
        busy_d      = busy_q;
        if (flush) begin
            out_valid_d = 1'b0;
            busy_d      = '0;
        end else begin
            if (accept) begin
                out_valid_d = 1'b1;
                pc_d        = PC;
                rs1_d       = rs1_rd;
                rs2_d       = rs2_rd;
                rd_d        = rd_w;
                opcode_d    = op_w;
                funct3_d    = instruction[14:12];
                funct7_d    = instruction[31:25];
                imm_d       = sext_data(decode_imm(instruction));
                btgt_d      = PC + sext_addr(b_imm(instruction));
                jtgt_d      = PC + sext_addr(j_imm(instruction));
            end else if (out_ready) begin
                out_valid_d = 1'b0;
            end
            // Clear before set so a same-cycle set of the same index wins.
            if (write) busy_d[write_reg] = 1'b0;
            if (accept && writes_rd(op_w, rd_w)) busy_d[rd_w] = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            pc_q        <= '0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            rd_q        <= '0;
            opcode_q    <= '0;
            funct3_q    <= '0;
            funct7_q    <= '0;
            imm_q       <= '0;
            btgt_q      <= '0;
            jtgt_q      <= '0;
            busy_q      <= '0;
            for (int i = 0; i < REG_COUNT; i++) rf_q[i] <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            pc_q        <= pc_d;
            rs1_q       <= rs1_d;
            rs2_q       <= rs2_d;
            rd_q        <= rd_d;
            opcode_q    <= opcode_d;
            funct3_q    <= funct3_d;
            funct7_q    <= funct7_d;
            imm_q       <= imm_d;
            btgt_q      <= btgt_d;
            jtgt_q      <= jtgt_d;
            busy_q      <= busy_d;
            if (write && write_reg != 5'd0) rf_q[write_reg] <= write_data;
        end
    end

    assign out_valid     = out_valid_q;
    assign out_PC        = pc_q;
    assign rs1_data      = rs1_q;
    assign rs2_data      = rs2_q;
    assign rd            = rd_q;
    assign opcode        = opcode_q;
    assign funct3        = funct3_q;
    assign funct7        = funct7_q;
    assign extend_imm    = imm_q;
    assign branch_target = btgt_q;
    assign JAL_target    = jtgt_q;

`ifndef SYNTHESIS
    logic [31:0] cycle_q;
    always_ff @(posedge clock) begin
        if (reset) cycle_q <= '0;
        else       cycle_q <= cycle_q + 32'd1;
        if (scan && $signed(cycle_q) >= SCAN_CYCLES_MIN && $signed(cycle_q) <= SCAN_CYCLES_MAX)
            $display("[core %0d] cycle %0d decode: pc=%h ins=%h in_v=%b in_r=%b haz=%b busy=%h | out_v=%b pc=%h rd=%0d op=%h imm=%h",
                     CORE, cycle_q, PC, instruction, in_valid, in_ready, hazard, busy_q,
                     out_valid_q, pc_q, rd_q, opcode_q, imm_q);
    end
`endif

endmodule

// File: tb/tb_decode_issue_unit.sv
// Directed bench for decode_issue_unit: decode fields, bypass, hazard stalls,
// targets, backpressure, flush and mid-stream reset.
module tb_decode_issue_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] PC;
    logic [31:0] instruction;
    logic        in_valid;
    logic        in_ready;
    logic        write;
    logic [4:0]  write_reg;
    logic [31:0] write_data;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_PC;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [4:0]  rd;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] extend_imm;
    logic [31:0] branch_target;
    logic [31:0] JAL_target;
    logic        scan;

    int total = 0;
    int bad   = 0;

    decode_issue_unit dut (
        .clock(clock), .reset(reset), .PC(PC), .instruction(instruction),
        .in_valid(in_valid), .in_ready(in_ready), .write(write), .write_reg(write_reg),
        .write_data(write_data), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .out_PC(out_PC), .rs1_data(rs1_data), .rs2_data(rs2_data), .rd(rd), .opcode(opcode),
        .funct3(funct3), .funct7(funct7), .extend_imm(extend_imm),
        .branch_target(branch_target), .JAL_target(JAL_target), .scan(scan)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0; PC = '0; instruction = '0; write = 1'b0;
        write_reg = '0; write_data = '0; flush = 1'b0; out_ready = 1'b0; scan = 1'b0;
        repeat (5) tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%0h exp=0", out_valid); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready got=%0h exp=0", in_ready); end
        total++; if (extend_imm !== 32'h0) begin bad++; $display("FAIL rst_imm got=%h exp=0", extend_imm); end
        total++; if (out_PC !== 32'h0 || rd !== 5'd0 || rs1_data !== 32'h0) begin
            bad++; $display("FAIL rst_data got pc=%h rd=%0d rs1=%h exp=0", out_PC, rd, rs1_data); end
        reset = 1'b0;
    endtask

    task automatic test_basic();
        in_valid = 1'b1; PC = 32'h4; instruction = 32'hfe010113; out_ready = 1'b1;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL basic_in_ready got=%0h exp=1", in_ready); end
        tick();
        in_valid = 1'b0;
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL basic_out_valid got=%0h exp=1", out_valid); end
        total++; if (rd !== 5'd2) begin bad++; $display("FAIL basic_rd got=%0d exp=2", rd); end
        total++; if (opcode !== 7'h13) begin bad++; $display("FAIL basic_opcode got=%h exp=13", opcode); end
        total++; if (funct3 !== 3'd0) begin bad++; $display("FAIL basic_funct3 got=%0d exp=0", funct3); end
        total++; if (extend_imm !== 32'hffffffe0) begin bad++; $display("FAIL basic_imm got=%h exp=ffffffe0", extend_imm); end
        total++; if (out_PC !== 32'h4) begin bad++; $display("FAIL basic_pc got=%h exp=4", out_PC); end
        // retire sp so the stores that follow do not stall on it
        write = 1'b1; write_reg = 5'd2; write_data = 32'h1000;
        tick();
        write = 1'b0;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL drain_out_valid got=%0h exp=0", out_valid); end
    endtask

    task automatic test_back_to_back();
        in_valid = 1'b1; PC = 32'h8; instruction = 32'h00112e23;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready0 got=%0h exp=1", in_ready); end
        tick();
        total++; if (opcode !== 7'h23 || funct3 !== 3'd2) begin bad++; $display("FAIL b2b_op0 got op=%h f3=%0d exp op=23 f3=2", opcode, funct3); end
        total++; if (extend_imm !== 32'h1c) begin bad++; $display("FAIL b2b_imm0 got=%h exp=1c", extend_imm); end
        total++; if (rs1_data !== 32'h1000) begin bad++; $display("FAIL b2b_rs1 got=%h exp=1000", rs1_data); end
        PC = 32'hc; instruction = 32'h00812c23;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready1 got=%0h exp=1", in_ready); end
        tick();
        in_valid = 1'b0;
        total++; if (out_valid !== 1'b1 || opcode !== 7'h23 || funct3 !== 3'd2) begin
            bad++; $display("FAIL b2b_op1 got v=%0h op=%h f3=%0d exp v=1 op=23 f3=2", out_valid, opcode, funct3); end
        total++; if (extend_imm !== 32'h18) begin bad++; $display("FAIL b2b_imm1 got=%h exp=18", extend_imm); end
        total++; if (out_PC !== 32'hc) begin bad++; $display("FAIL b2b_pc1 got=%h exp=c", out_PC); end
        tick();
    endtask

    task automatic test_hazard();
        in_valid = 1'b1; PC = 32'h10; instruction = 32'h00400793;
        tick();
        PC = 32'h14; instruction = 32'hfef42623;
        for (int i = 0; i < 2; i++) begin
            #1;
            total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL haz_stall%0d got=%0h exp=0", i, in_ready); end
            tick();
        end
        write = 1'b1; write_reg = 5'd15; write_data = 32'h4;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL haz_release got=%0h exp=1", in_ready); end
        tick();
        write = 1'b0;
        total++; if (out_valid !== 1'b1 || opcode !== 7'h23) begin bad++; $display("FAIL haz_out got v=%0h op=%h exp v=1 op=23", out_valid, opcode); end
        total++; if (rs2_data !== 32'h4) begin bad++; $display("FAIL haz_bypass got=%h exp=4", rs2_data); end
        total++; if (extend_imm !== 32'hffffffec) begin bad++; $display("FAIL haz_imm got=%h exp=ffffffec", extend_imm); end
        total++; if (rs1_data !== 32'h0) begin bad++; $display("FAIL haz_rs1 got=%h exp=0", rs1_data); end
        PC = 32'h18; instruction = 32'h00078513;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL haz_busy_clear got=%0h exp=1", in_ready); end
        tick();
        in_valid = 1'b0;
        total++; if (rs1_data !== 32'h4) begin bad++; $display("FAIL haz_rf_read got=%h exp=4", rs1_data); end
        tick();
    endtask

    task automatic test_targets();
        in_valid = 1'b1; PC = 32'h100; instruction = 32'h00000463;
        tick();
        total++; if (branch_target !== 32'h108) begin bad++; $display("FAIL tgt_branch got=%h exp=108", branch_target); end
        total++; if (extend_imm !== 32'h8) begin bad++; $display("FAIL tgt_bimm got=%h exp=8", extend_imm); end
        PC = 32'h20; instruction = 32'h010000ef;
        tick();
        in_valid = 1'b0;
        total++; if (JAL_target !== 32'h30) begin bad++; $display("FAIL tgt_jal got=%h exp=30", JAL_target); end
        total++; if (rd !== 5'd1) begin bad++; $display("FAIL tgt_jal_rd got=%0d exp=1", rd); end
        total++; if (branch_target !== 32'h820) begin bad++; $display("FAIL tgt_jal_btgt got=%h exp=820", branch_target); end
    endtask

    task automatic test_backpressure_flush();
        out_ready = 1'b0; in_valid = 1'b1; PC = 32'h40; instruction = 32'h00008193;
        for (int i = 0; i < 4; i++) begin
            #1;
            total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready%0d got=%0h exp=0", i, in_ready); end
            tick();
            total++; if (out_valid !== 1'b1 || out_PC !== 32'h20 || JAL_target !== 32'h30 || rd !== 5'd1) begin
                bad++; $display("FAIL bp_hold%0d got v=%0h pc=%h jt=%h rd=%0d exp v=1 pc=20 jt=30 rd=1", i, out_valid, out_PC, JAL_target, rd); end
        end
        flush = 1'b1;
        #1;
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL flush_in_ready got=%0h exp=0", in_ready); end
        tick();
        flush = 1'b0;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_out_valid got=%0h exp=0", out_valid); end
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL flush_busy_clear got=%0h exp=1", in_ready); end
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        total++; if (out_valid !== 1'b1 || rd !== 5'd3 || out_PC !== 32'h40) begin
            bad++; $display("FAIL flush_next got v=%0h rd=%0d pc=%h exp v=1 rd=3 pc=40", out_valid, rd, out_PC); end
        tick();
    endtask

    task automatic test_reset_mid();
        write = 1'b1; write_reg = 5'd8; write_data = 32'h55;
        tick();
        write = 1'b0;
        in_valid = 1'b1; PC = 32'h50; instruction = 32'h00100413; out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        total++; if (out_valid !== 1'b1 || rd !== 5'd8) begin bad++; $display("FAIL mid_pre got v=%0h rd=%0d exp v=1 rd=8", out_valid, rd); end
        reset = 1'b1;
        tick();
        total++; if (out_valid !== 1'b0 || rd !== 5'd0 || extend_imm !== 32'h0) begin
            bad++; $display("FAIL mid_reset got v=%0h rd=%0d imm=%h exp 0", out_valid, rd, extend_imm); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL mid_reset_ready got=%0h exp=0", in_ready); end
        reset = 1'b0; out_ready = 1'b1; in_valid = 1'b1; PC = 32'h60; instruction = 32'h00040493;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL mid_busy_clear got=%0h exp=1", in_ready); end
        tick();
        in_valid = 1'b0;
        total++; if (rs1_data !== 32'h0 || rd !== 5'd9) begin bad++; $display("FAIL mid_x8 got rs1=%h rd=%0d exp rs1=0 rd=9", rs1_data, rd); end
        tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_hazard();
        test_targets();
        test_backpressure_flush();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
